// File: rtl/game_pkg.sv
// Shared definitions for the game: status encodings seen by the pipe generator
// and renderer, BCD score geometry and a BCD magnitude compare.
package game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READY = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_DYING = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 3;
  localparam int SCORE_W    = BCD_W * BCD_DIGITS;

  // Valid BCD keeps digit weights ordered, so a plain unsigned compare is exact.
  function automatic logic bcd_gt(input logic [SCORE_W-1:0] a,
                                  input logic [SCORE_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/game_controller_bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear and saturation at 999.
module bcd_counter3
  import game_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  localparam logic [SCORE_W-1:0] MAX_VALUE = 12'h999;
  localparam logic [BCD_W-1:0]   DIGIT_MAX = 4'd9;

  logic [SCORE_W-1:0] value_inc;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    value_inc = value;
    if (value[3:0] != DIGIT_MAX) begin
      value_inc[3:0] = value[3:0] + 4'd1;
    end else begin
      value_inc[3:0] = '0;
      if (value[7:4] != DIGIT_MAX) begin
        value_inc[7:4] = value[7:4] + 4'd1;
      end else begin
        value_inc[7:4]  = '0;
        value_inc[11:8] = value[11:8] + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != MAX_VALUE)) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: synchronizes frame sync and button, debounces presses per
// frame, runs IDLE/READY/PLAY/DYING/OVER and keeps BCD score and best score.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned READY_FRAMES = 60,
  parameter int unsigned DEATH_FRAMES = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vga_sync,
  input  logic               button,
  input  logic               collision,
  input  logic               pipe_refresh,
  output logic [2:0]         status,
  output logic               flap,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best
);

  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

  logic       vga_s1, vga_s2, vga_s2_d;
  logic       btn_s1, btn_s2, btn_s2_d;
  logic       press_raw;
  logic       armed;
  logic       press_ok;
  logic [7:0] frame_cnt;
  logic [2:0] next_status;
  logic       flap_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_s1     <= 1'b0;
      vga_s2     <= 1'b0;
      vga_s2_d   <= 1'b0;
      frame_tick <= 1'b0;
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_s2_d   <= 1'b0;
      press_raw  <= 1'b0;
      armed      <= 1'b1;
    end else begin
      vga_s1     <= vga_sync;
      vga_s2     <= vga_s1;
      vga_s2_d   <= vga_s2;
      frame_tick <= vga_s2 & ~vga_s2_d;
      btn_s1     <= button;
      btn_s2     <= btn_s1;
      btn_s2_d   <= btn_s2;
      press_raw  <= btn_s2 & ~btn_s2_d;
      // Acceptance disarms; the next frame re-arms, limiting presses to one per frame.
      if (press_ok) begin
        armed <= 1'b0;
      end else if (frame_tick) begin
        armed <= 1'b1;
      end
    end
  end

  assign press_ok = press_raw & armed;

  always_comb begin
    next_status = status;
    case (status)
      ST_IDLE:  if (press_ok) next_status = ST_READY;
      ST_READY: begin
        if (press_ok || (frame_tick && (frame_cnt == READY_LAST))) begin
          next_status = ST_PLAY;
        end
      end
      ST_PLAY:  if (collision) next_status = ST_DYING;
      ST_DYING: if (frame_tick && (frame_cnt == DEATH_LAST)) next_status = ST_OVER;
      ST_OVER:  if (press_ok) next_status = ST_IDLE;
      default:  next_status = ST_IDLE;
    endcase
  end

  // A collision in the same cycle as a press wins: the bird is already dying.
  assign flap_next = press_ok &&
                     ((status == ST_READY) || ((status == ST_PLAY) && !collision));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status    <= ST_IDLE;
      flap      <= 1'b0;
      frame_cnt <= '0;
      best      <= '0;
    end else begin
      status <= next_status;
      flap   <= flap_next;
      if (next_status != status) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if ((status == ST_DYING) && (next_status == ST_OVER) && bcd_gt(score, best)) begin
        best <= score;
      end
    end
  end

  bcd_counter3 u_score (
    .clock (clock),
    .reset (reset),
    .clear (next_status == ST_IDLE),
    .inc   ((status == ST_PLAY) && pipe_refresh),
    .value (score)
  );

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with short READY/DEATH frame counts.
module tb_game_controller;
  import game_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vga_sync = 1'b0;
  logic        button = 1'b0;
  logic        collision = 1'b0;
  logic        pipe_refresh = 1'b0;
  logic [2:0]  status;
  logic        flap;
  logic        frame_tick;
  logic [11:0] score;
  logic [11:0] best;

  int n_cmp = 0;
  int n_err = 0;
  int flap_cnt = 0;

  always #5 clock = ~clock;

  game_controller #(
    .READY_FRAMES (4),
    .DEATH_FRAMES (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .vga_sync     (vga_sync),
    .button       (button),
    .collision    (collision),
    .pipe_refresh (pipe_refresh),
    .status       (status),
    .flap         (flap),
    .frame_tick   (frame_tick),
    .score        (score),
    .best         (best)
  );

  always @(negedge clock) begin
    if (flap) flap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_frame();
    vga_sync = 1'b1;
    steps(4);
    vga_sync = 1'b0;
    steps(4);
  endtask

  task automatic press();
    button = 1'b1;
    steps(3);
    button = 1'b0;
    steps(6);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_refresh = 1'b1;
      step();
      pipe_refresh = 1'b0;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_flap"},   32'(flap),   32'd0);
    check({tag, "_tick"},   32'(frame_tick), 32'd0);
    check({tag, "_score"},  32'(score),  32'h000);
    check({tag, "_best"},   32'(best),   32'h000);
  endtask

  initial begin
    steps(2);
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // First press: status changes exactly 4 clocks after the button edge.
    button = 1'b1;
    steps(3);
    check("press_lat3", 32'(status), 32'(ST_IDLE));
    step();
    check("press_lat4", 32'(status), 32'(ST_READY));
    button = 1'b0;
    steps(5);

    // Frame tick appears 3 clocks after vga_sync rises, for one cycle.
    vga_sync = 1'b1;
    steps(2);
    check("tick_lat2", 32'(frame_tick), 32'd0);
    step();
    check("tick_lat3", 32'(frame_tick), 32'd1);
    step();
    check("tick_lat4", 32'(frame_tick), 32'd0);
    vga_sync = 1'b0;
    steps(4);

    press();
    check("ready_to_play", 32'(status), 32'(ST_PLAY));
    check("flap_on_start", 32'(flap_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_frame();
      press();
    end
    check("play_flaps", 32'(flap_cnt), 32'd4);
    check("play_status", 32'(status), 32'(ST_PLAY));

    // Second press inside the same frame is dropped.
    do_frame();
    press();
    press();
    check("debounce", 32'(flap_cnt), 32'd5);

    pulses(9);
    check("score_009", 32'(score), 32'h009);
    pulses(1);
    check("score_010", 32'(score), 32'h010);
    pulses(31);
    check("score_041", 32'(score), 32'h041);

    collision    = 1'b1;
    pipe_refresh = 1'b1;
    step();
    collision    = 1'b0;
    pipe_refresh = 1'b0;
    check("coll_refresh_score", 32'(score), 32'h042);
    check("coll_refresh_status", 32'(status), 32'(ST_DYING));

    do_frame();
    press();
    check("dying_press_status", 32'(status), 32'(ST_DYING));
    check("dying_press_flap", 32'(flap_cnt), 32'd5);
    do_frame();
    check("dying_frame2", 32'(status), 32'(ST_DYING));
    do_frame();
    check("over_status", 32'(status), 32'(ST_OVER));
    check("best_042", 32'(best), 32'h042);

    press();
    check("over_press_status", 32'(status), 32'(ST_IDLE));
    check("over_press_score", 32'(score), 32'h000);

    // Game 2: automatic start after exactly 4 frames in READY.
    do_frame();
    press();
    check("g2_ready", 32'(status), 32'(ST_READY));
    steps(3);
    do_frame();
    do_frame();
    do_frame();
    check("g2_ready_3frames", 32'(status), 32'(ST_READY));
    do_frame();
    check("g2_auto_play", 32'(status), 32'(ST_PLAY));
    check("g2_no_flap", 32'(flap_cnt), 32'd5);

    pulses(10);
    check("g2_score_010", 32'(score), 32'h010);

    // Accepted press in the same cycle as collision: dying, no flap.
    do_frame();
    button = 1'b1;
    steps(3);
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("coll_press_status", 32'(status), 32'(ST_DYING));
    button = 1'b0;
    steps(5);
    check("coll_press_flap", 32'(flap_cnt), 32'd5);
    do_frame();
    do_frame();
    do_frame();
    check("g2_over", 32'(status), 32'(ST_OVER));
    check("g2_best_kept", 32'(best), 32'h042);
    do_frame();
    press();
    check("g2_idle", 32'(status), 32'(ST_IDLE));

    // Game 3: reset mid-play clears everything, including best.
    do_frame();
    press();
    do_frame();
    press();
    check("g3_play", 32'(status), 32'(ST_PLAY));
    pulses(17);
    check("g3_score_017", 32'(score), 32'h017);
    check("g3_best_042", 32'(best), 32'h042);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    vga_sync = 1'b1;
    button   = 1'b1;
    steps(4);
    check_all_zero("held_reset");
    reset    = 1'b0;
    vga_sync = 1'b0;
    button   = 1'b0;
    steps(4);

    // Game 4: BCD carries and saturation.
    press();
    check("g4_ready", 32'(status), 32'(ST_READY));
    do_frame();
    press();
    check("g4_play", 32'(status), 32'(ST_PLAY));
    pulses(99);
    check("score_099", 32'(score), 32'h099);
    pulses(1);
    check("score_100", 32'(score), 32'h100);
    pulses(899);
    check("score_999", 32'(score), 32'h999);
    pulses(1);
    check("score_sat", 32'(score), 32'h999);
    check("g4_status", 32'(status), 32'(ST_PLAY));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for the Flappy-style game. It owns the 3-bit `status` bus that drives the pipe generator (status 2 = playing) and the renderer. It turns the player button, the collision flag and the pipe generator's `pipe_refresh` pulse into state transitions, flap pulses and a BCD score/best score. It also produces the per-frame tick that the rest of the game logic uses.

## Interface
- `READY_FRAMES`, 60: frames spent in READY before play starts automatically (1–255).
- `DEATH_FRAMES`, 30: frames spent in DYING before OVER (1–255).
- `clock` in 1: system clock.
- `reset` in 1: reset, **asynchronous, active-high**.
- `vga_sync` in 1: raw frame sync from the VGA timing block; asynchronous to `clock`.
- `button` in 1: raw player button, active-high; asynchronous.
- `collision` in 1: level from the collision checker; synchronous.
- `pipe_refresh` in 1: one-cycle pulse from the pipe generator for each pipe passed; synchronous.
- `status` out 3: game state; 0 IDLE, 1 READY, 2 PLAY, 3 DYING, 4 OVER.
- `flap` out 1: one-cycle pulse that commands the bird to jump.
- `frame_tick` out 1: one-cycle pulse per frame.
- `score` out 12: 3-digit BCD current score.
- `best` out 12: 3-digit BCD best score since reset.

## Operation
- `vga_sync` path:
  - Passes through a 2-flop synchronizer, then a rising-edge detector, producing `frame_tick`.
- `button` path:
  - Passes through a 2-flop synchronizer, then a rising-edge detector, producing a raw press.
  - A raw press is accepted only if at least one `frame_tick` has occurred since the last accepted press (debounce). Other presses are dropped.
- 8-bit frame counter:
  - Cleared on every state entry.
  - Incremented on each `frame_tick`.
- IDLE:
  - `score` is held at 0.
  - Accepted press → READY.
- READY:
  - Accepted press → PLAY, and `flap` pulses in the same cycle as the transition.
  - Frame counter reaching READY_FRAMES−1 while a `frame_tick` is present → PLAY, with no flap.
- PLAY:
  - Accepted press → `flap` pulse.
  - `pipe_refresh` → `score` increments in BCD (009→010, 099→100) and saturates at 999.
  - `collision` high → DYING.
- DYING:
  - Presses are ignored and produce no flap.
  - Frame counter reaching DEATH_FRAMES−1 while a `frame_tick` is present → OVER.
  - On that same transition, `best` is loaded with `score` if `score` > `best` (BCD compare).
- OVER:
  - Accepted press → IDLE, and `score` clears to 0 on entry to IDLE.
- Simultaneous events in PLAY:
  - `collision` together with `pipe_refresh`: the score increments and the state goes to DYING.
  - `collision` together with an accepted press: the state goes to DYING and no flap is issued.
- `pipe_refresh` and `collision` are ignored outside PLAY.
- Undefined `status` codes 5–7 → IDLE on the next clock.

## Timing
- All outputs are registered.
- Reset values: `status`=0, `score`=0, `best`=0, `flap`=0, `frame_tick`=0. The frame counter and the debounce flag also reset.
- The debounce flag resets to "armed", so the first press after reset is accepted.
- `frame_tick` asserts 3 clocks after the `vga_sync` rising edge is sampled.
- An accepted press affects `status`/`flap` 4 clocks after the `button` rising edge.
- `pipe_refresh` → `score` update: 1 clock.
- `collision` → `status`=3: 1 clock.
- `reset` asserted mid-operation forces every register to its reset value immediately, including `best`.

## Structure
- Package `game_pkg`:
  - Status encodings ST_IDLE..ST_OVER, shared with the pipe generator and renderer.
  - BCD digit width constant.
  - BCD greater-than function.
- Sub-module `bcd_counter3`:
  - 3-digit BCD incrementer with synchronous clear, increment enable and saturation at 999.
  - Instantiated once, for `score`.
- Synchronizers and edge detectors stay inline.

## Test plan
- Reset, then 5 presses spaced ≥1 frame apart, READY_FRAMES=4:
  - `status` goes 0→1→2.
  - Each press in PLAY gives exactly one `flap` pulse.
  - No presses in READY → PLAY after exactly 4 `frame_tick`s, with no flap.
- Two presses within one frame:
  - Only the first is accepted (one state change or one flap).
- In PLAY, 100 `pipe_refresh` pulses:
  - `score` = 0x100.
  - Preload `score` to 0x999, then one more pulse → stays 0x999.
- `collision` and `pipe_refresh` in the same cycle at score 0x041:
  - `score`=0x042 and `status`=3.
  - After DEATH_FRAMES ticks, `status`=4 and `best`=0x042.
  - Next game ends at 0x010 → `best` stays 0x042.
- Press during DYING:
  - No flap and no state change.
- Press in OVER:
  - `status`=0 and `score`=0.
- Assert `reset` mid-PLAY with `score`=0x017 and `best`=0x042:
  - All outputs are 0 within the same cycle and stay 0 while `reset` is high.
